// File: rtl/apb_master_if.sv
// Command/response and APB bus bundle for apb_master.
// master modport is the bridge side; slave modport is the command source plus completer.
interface apb_master_if;
    logic       cmd_valid;
    logic       cmd_ready;
    logic       cmd_write;
    logic [7:0] cmd_addr;
    logic [7:0] cmd_wdata;
    logic       rsp_valid;
    logic [7:0] rsp_rdata;
    logic       rsp_error;
    logic       psel;
    logic       penable;
    logic       pwrite;
    logic [7:0] paddr;
    logic [7:0] pwdata;
    logic [7:0] prdata;
    logic       pready;

    modport master (
        input  cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        input  prdata, pready,
        output cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        output psel, penable, pwrite, paddr, pwdata
    );

    modport slave (
        output cmd_valid, cmd_write, cmd_addr, cmd_wdata,
        output prdata, pready,
        input  cmd_ready, rsp_valid, rsp_rdata, rsp_error,
        input  psel, penable, pwrite, paddr, pwdata
    );
endinterface

// File: rtl/apb_master.sv
// Single-outstanding APB requester: IDLE -> SETUP -> ACCESS, one-cycle response pulse.
// Optional ACCESS wait timeout enabled by defining APB_MASTER_TIMEOUT_EN.
module apb_master #(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic          pclk,
    input  logic          preset,
    apb_master_if.master  bus
);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t     r_state;
    state_t     w_state_nxt;
    logic       r_pwrite;
    logic [7:0] r_paddr;
    logic [7:0] r_pwdata;
    logic [7:0] r_rsp_rdata;
    logic       r_rsp_valid;
    logic       w_accept;
    logic       w_done;
    logic       w_abort;
    logic       w_cmd_ready;
    logic       w_psel;
    logic       w_penable;

    generate
        if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_bad_timeout
            $error("apb_master: TIMEOUT_CYCLES must be 1..255");
        end
    endgenerate

    assign w_accept = (r_state == ST_IDLE) && bus.cmd_valid;
    assign w_done   = (r_state == ST_ACCESS) && bus.pready;

`ifdef APB_MASTER_TIMEOUT_EN
    localparam logic [7:0] LP_WAIT_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] r_wait_cnt;
    logic       r_rsp_error;

    // abort on the edge that would bring the wait count up to the limit
    assign w_abort = (r_state == ST_ACCESS) && !bus.pready &&
                     (r_wait_cnt == LP_WAIT_LAST);

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_wait_cnt <= 8'h00;
        end else if (r_state == ST_SETUP) begin
            r_wait_cnt <= 8'h00;
        end else if ((r_state == ST_ACCESS) && !bus.pready) begin
            r_wait_cnt <= r_wait_cnt + 8'h01;
        end
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_rsp_error <= 1'b0;
        end else if (w_done || w_abort) begin
            r_rsp_error <= w_abort;
        end
    end

    assign bus.rsp_error = r_rsp_error;
`else
    assign w_abort       = 1'b0;
    assign bus.rsp_error = 1'b0;
`endif

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        unique case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = ST_SETUP;
                end
            end
            ST_SETUP: begin
                w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (w_done || w_abort) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // control strobes decode only the state register
    always_comb begin
        w_cmd_ready = 1'b0;
        w_psel      = 1'b0;
        w_penable   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_cmd_ready = 1'b1;
            end
            ST_SETUP: begin
                w_psel = 1'b1;
            end
            ST_ACCESS: begin
                w_psel    = 1'b1;
                w_penable = 1'b1;
            end
            default: begin
                w_cmd_ready = 1'b0;
            end
        endcase
    end

    always_ff @(posedge pclk) begin
        if (preset) begin
            r_pwrite    <= 1'b0;
            r_paddr     <= 8'h00;
            r_pwdata    <= 8'h00;
            r_rsp_rdata <= 8'h00;
            r_rsp_valid <= 1'b0;
        end else begin
            if (w_accept) begin
                r_pwrite <= bus.cmd_write;
                r_paddr  <= bus.cmd_addr;
                r_pwdata <= bus.cmd_wdata;
            end
            r_rsp_valid <= w_done || w_abort;
            if (w_done) begin
                r_rsp_rdata <= r_pwrite ? 8'h00 : bus.prdata;
            end else if (w_abort) begin
                r_rsp_rdata <= 8'h00;
            end
        end
    end

    assign bus.cmd_ready = w_cmd_ready;
    assign bus.psel      = w_psel;
    assign bus.penable   = w_penable;
    assign bus.pwrite    = r_pwrite;
    assign bus.paddr     = r_paddr;
    assign bus.pwdata    = r_pwdata;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;

endmodule

// File: tb/tb_apb_master.sv
// Randomized bench for apb_master with a wait-state APB completer and a
// transaction-level memory/latency reference model.
module tb_apb_master;

    localparam int TO = 4;
`ifdef APB_MASTER_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    int   n_checks = 0;
    int   n_errors = 0;

    apb_master_if bus ();

    apb_master #(.TIMEOUT_CYCLES(TO)) dut (
        .pclk   (clk),
        .preset (rst),
        .bus    (bus.master)
    );

    always #5 clk = ~clk;

    // completer: pready rises after waits_cfg ACCESS cycles
    logic [7:0] s_mem [256];
    int         s_wcnt = 0;
    int         waits_cfg = 0;

    assign bus.pready = bus.psel && bus.penable && (s_wcnt >= waits_cfg);
    assign bus.prdata = s_mem[bus.paddr];

    always @(posedge clk) begin
        if (bus.psel && bus.penable && !bus.pready) s_wcnt <= s_wcnt + 1;
        else s_wcnt <= 0;
        if (bus.psel && bus.penable && bus.pready && bus.pwrite)
            s_mem[bus.paddr] <= bus.pwdata;
    end

    logic [7:0] exp_mem [256];
    logic [7:0] pool [8];

    task automatic check(input string tag, input logic [31:0] got,
                         input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic xfer(input bit wr, input logic [7:0] a,
                        input logic [7:0] d, input int w);
        bit         abort;
        int         exp_lat;
        logic [7:0] exp_rd;
        int         lat;
        bit         got;
        abort   = TO_EN && (w >= TO);
        exp_lat = abort ? (2 + TO) : (3 + w);
        exp_rd  = (abort || wr) ? 8'h00 : exp_mem[a];
        waits_cfg = w;
        @(negedge clk);
        check("idle_rdy", 32'(bus.cmd_ready), 1);
        bus.cmd_write = wr;
        bus.cmd_addr  = a;
        bus.cmd_wdata = d;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        bus.cmd_addr  = ~a;
        bus.cmd_wdata = ~d;
        lat = 0;
        got = 1'b0;
        while (!got && lat < 100) begin
            @(negedge clk);
            lat++;
            if (lat == 1) begin
                check("setup_psel", 32'(bus.psel), 1);
                check("setup_pen", 32'(bus.penable), 0);
                check("setup_addr", 32'(bus.paddr), 32'(a));
                check("setup_wr", 32'(bus.pwrite), 32'(wr));
                check("setup_wdata", 32'(bus.pwdata), 32'(d));
                check("setup_rdy", 32'(bus.cmd_ready), 0);
            end else if (bus.rsp_valid) begin
                got = 1'b1;
            end else begin
                check("acc_sel_en", {30'd0, bus.psel, bus.penable}, 3);
                check("acc_addr", 32'(bus.paddr), 32'(a));
                check("acc_wdata", 32'(bus.pwdata), 32'(d));
                check("acc_rdy", 32'(bus.cmd_ready), 0);
            end
        end
        check("rsp_seen", 32'(got), 1);
        check("rsp_latency", 32'(lat), 32'(exp_lat));
        check("rsp_rdata", 32'(bus.rsp_rdata), 32'(exp_rd));
        check("rsp_error", 32'(bus.rsp_error), 32'(abort));
        check("rsp_psel", {30'd0, bus.psel, bus.penable}, 0);
        check("rsp_rdy", 32'(bus.cmd_ready), 1);
        check("rsp_hold", {bus.pwrite, bus.paddr, bus.pwdata},
              {wr, a, d});
        if (wr && !abort) exp_mem[a] = d;
        @(negedge clk);
        check("rsp_pulse", 32'(bus.rsp_valid), 0);
    endtask

    initial begin
        int         qc;
        int         first_c;
        int         second_c;
        logic [7:0] second_d;
        int         b_acc;
        int         n_rsp;
        logic [7:0] da;
        pool[0] = 8'h10; pool[1] = 8'h00; pool[2] = 8'hFF; pool[3] = 8'h55;
        pool[4] = 8'hAA; pool[5] = 8'h01; pool[6] = 8'h80; pool[7] = 8'h7F;
        rst = 1'b1;
        bus.cmd_valid = 1'b0;
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h00;
        bus.cmd_wdata = 8'h00;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("rst_ctrl", {29'd0, bus.psel, bus.penable, bus.pwrite}, 0);
        check("rst_bus", {16'd0, bus.paddr, bus.pwdata}, 0);
        check("rst_rsp", {22'd0, bus.rsp_valid, bus.rsp_error, bus.rsp_rdata}, 0);
        check("rst_rdy", 32'(bus.cmd_ready), 1);

        xfer(1'b1, 8'h10, 8'hA5, 0);
        xfer(1'b0, 8'h10, 8'h00, 0);
        xfer(1'b0, 8'h10, 8'h3C, 3);
        for (int i = 1; i < 8; i++) xfer(1'b1, pool[i], 8'($urandom), 0);

        for (int i = 0; i < 40; i++) begin
            xfer(1'($urandom), pool[$urandom_range(0, 7)], 8'($urandom),
                 int'($urandom_range(0, 5)));
        end

        // back-to-back: second command held during the first transfer
        da = 8'($urandom);
        waits_cfg = 0;
        @(negedge clk);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'h55;
        bus.cmd_wdata = da;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_write = 1'b0;
        bus.cmd_wdata = 8'h00;
        first_c = -1; second_c = -1; second_d = 8'h00; b_acc = -1; n_rsp = 0;
        for (qc = 1; qc <= 9; qc++) begin
            @(negedge clk);
            if (bus.psel) check("q_busy_rdy", 32'(bus.cmd_ready), 0);
            if (bus.rsp_valid) begin
                n_rsp++;
                if (first_c < 0) first_c = qc;
                else begin second_c = qc; second_d = bus.rsp_rdata; end
            end
            if (b_acc < 0 && bus.cmd_ready) begin
                b_acc = qc;
                @(posedge clk);
                #1 bus.cmd_valid = 1'b0;
            end
        end
        exp_mem[8'h55] = da;
        check("q_rsp_count", 32'(n_rsp), 2);
        check("q_first_rsp", 32'(first_c), 3);
        check("q_b_accept", 32'(b_acc), 3);
        check("q_second_rsp", 32'(second_c), 6);
        check("q_second_data", 32'(second_d), 32'(da));

        // reset in the second ACCESS cycle aborts silently
        waits_cfg = 5;
        @(negedge clk);
        bus.cmd_write = 1'b1;
        bus.cmd_addr  = 8'hAA;
        bus.cmd_wdata = ~exp_mem[8'hAA];
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        repeat (3) @(negedge clk);
        check("ra_access", {30'd0, bus.psel, bus.penable}, 3);
        rst = 1'b1;
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("ra_sel_en", {30'd0, bus.psel, bus.penable}, 0);
        check("ra_rdy", 32'(bus.cmd_ready), 1);
        check("ra_rsp", 32'(bus.rsp_valid), 0);
        n_rsp = 0;
        repeat (8) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        check("ra_no_rsp", 32'(n_rsp), 0);
        xfer(1'b0, 8'hAA, 8'h00, 1);

`ifdef APB_MASTER_TIMEOUT_EN
        xfer(1'b0, 8'h10, 8'h00, 1000);
        xfer(1'b1, 8'h01, 8'h5A, 1000);
        xfer(1'b0, 8'h01, 8'h00, TO - 1);
`else
        waits_cfg = 1000;
        @(negedge clk);
        bus.cmd_write = 1'b0;
        bus.cmd_addr  = 8'h10;
        bus.cmd_valid = 1'b1;
        @(posedge clk);
        #1 bus.cmd_valid = 1'b0;
        n_rsp = 0;
        repeat (102) begin
            @(negedge clk);
            if (bus.rsp_valid) n_rsp++;
        end
        check("hang_no_rsp", 32'(n_rsp), 0);
        check("hang_access", {30'd0, bus.psel, bus.penable}, 3);
        waits_cfg = 0;
        qc = 0;
        while (!bus.rsp_valid && qc < 5) begin
            @(negedge clk);
            qc++;
        end
        check("hang_release", 32'(bus.rsp_valid), 1);
        check("hang_rdata", 32'(bus.rsp_rdata), 32'(exp_mem[8'h10]));
        check("hang_error", 32'(bus.rsp_error), 0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/apb_master.md
APB_MASTER -- requirements
Module: apb_master

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16: ACCESS cycles without pready before abort, legal 1..255, used only with APB_MASTER_TIMEOUT_EN.
REQ-002 SHALL have port pclk, input, 1: the single clock; all state changes on its rising edge.
REQ-003 SHALL have port preset, input, 1: reset, synchronous and active-high.
REQ-004 SHALL have port cmd_valid, input, 1: command request.
REQ-005 SHALL have port cmd_ready, output, 1: command accepted when cmd_valid and cmd_ready are both high at a rising edge.
REQ-006 SHALL have port cmd_write, input, 1: 1 means write, 0 means read.
REQ-007 SHALL have port cmd_addr, input, 8: transfer address.
REQ-008 SHALL have port cmd_wdata, input, 8: write data.
REQ-009 SHALL have port rsp_valid, output, 1: one-cycle completion pulse.
REQ-010 SHALL have port rsp_rdata, output, 8: read data, valid while rsp_valid is high.
REQ-011 SHALL have port rsp_error, output, 1: timeout abort flag, valid while rsp_valid is high.
REQ-012 SHALL have ports psel, penable, pwrite (output, 1 each) and paddr, pwdata (output, 8 each): APB request.
REQ-013 SHALL have ports prdata (input, 8) and pready (input, 1): APB completer response.

Function
REQ-014 SHALL implement a three-state FSM: IDLE, SETUP and ACCESS.
REQ-015 All outputs SHALL be driven from registers; no input-to-output combinational paths.
REQ-016 cmd_ready SHALL be 1 only in IDLE; cmd_* SHALL be ignored in other states.
REQ-017 On accept, SHALL capture cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
REQ-018 SETUP SHALL last exactly one cycle with psel=1, penable=0, then go to ACCESS.
REQ-019 ACCESS SHALL drive psel=1, penable=1 and stay in ACCESS while pready=0 at the rising edge.
REQ-020 pwrite/paddr/pwdata SHALL stay stable from SETUP until the cycle after completion.
REQ-021 Completion SHALL be a rising edge in ACCESS with pready=1; at that edge the block SHALL go to IDLE, clear psel and penable, and set rsp_valid=1 for exactly one cycle.
REQ-022 On a read completion, rsp_rdata SHALL be set to prdata sampled at the completion edge; on a write completion, rsp_rdata SHALL be 0.
REQ-023 With a zero-wait completer, rsp_valid SHALL be high in the third cycle after the accept edge; each wait cycle SHALL add one cycle.
REQ-024 pready SHALL be ignored in IDLE and SETUP; this tolerates a completer whose registered pready lingers one cycle.
REQ-025 At least one IDLE cycle SHALL separate transfers; cmd_ready=1 during the rsp_valid cycle is legal and permits acceptance.

Reset
REQ-026 While preset=1 at a rising edge: FSM to IDLE; psel, penable, pwrite, rsp_valid, rsp_error = 0; paddr, pwdata, rsp_rdata = 0x00; cmd_ready = 1 after reset.
REQ-027 Reset during SETUP or ACCESS SHALL abort the transfer silently: no rsp_valid, and psel=0 in the next cycle.

Configuration
REQ-028 Macro APB_MASTER_TIMEOUT_EN defined: an 8-bit wait counter SHALL clear on entry to ACCESS and increment on each ACCESS edge with pready=0.
REQ-029 When the count reaches TIMEOUT_CYCLES, the block SHALL abort: go to IDLE, pulse rsp_valid with rsp_error=1 and rsp_rdata=0.
REQ-030 If pready=1 on the same edge as the timeout, normal completion SHALL take precedence.
REQ-031 Macro APB_MASTER_TIMEOUT_EN undefined: ACCESS SHALL wait indefinitely, rsp_error SHALL be tied to 0, and no counter logic SHALL exist.

Verification
REQ-032 Write 0xA5 to 0x10 against the team APB slave -> SETUP shows psel=1, penable=0, paddr=0x10, pwrite=1, pwdata=0xA5; then rsp_valid pulse with rsp_error=0.
REQ-033 Read 0x10 after REQ-032 -> rsp_rdata=0xA5, rsp_valid high for one cycle.
REQ-034 pready held 0 for 3 ACCESS cycles, then 1 -> psel, penable, paddr and pwdata stable throughout; rsp_valid exactly 3 cycles later than the zero-wait case.
REQ-035 cmd_valid held high with two queued commands -> cmd_ready=0 during SETUP and ACCESS; second command accepted only in IDLE; no lost or duplicated transfer.
REQ-036 preset=1 during the 2nd ACCESS cycle -> next cycle psel=0, penable=0, cmd_ready=1; no rsp_valid.
REQ-037 APB_MASTER_TIMEOUT_EN defined, TIMEOUT_CYCLES=4, pready tied 0 -> abort after 4 ACCESS cycles with rsp_valid=1, rsp_error=1, rsp_rdata=0x00. Macro undefined -> still in ACCESS after 100 cycles.
